// File: rtl/io_delay_pkg.sv
// io_delay_pkg: shared widths and tap type for the IO delay line.
package io_delay_pkg;
   localparam int TAP_W = 5;
   localparam int NUM_TAPS = 32;
   typedef logic [TAP_W-1:0] tap_t;
endpackage

// File: rtl/io_delay_line_if.sv
// io_delay_line_if: control/data bundle for both delay channels plus rdy.
interface io_delay_line_if;
   import io_delay_pkg::*;
   logic idly_ld, idly_ce, idly_inc;
   tap_t idly_cntvaluein, idly_cntvalueout;
   logic idatain, idataout;
   logic odly_ld, odly_ce, odly_inc;
   tap_t odly_cntvaluein, odly_cntvalueout;
   logic odatain, odataout;
   logic rdy;
   modport master (
      output idly_ld, idly_ce, idly_inc, idly_cntvaluein, idatain,
      output odly_ld, odly_ce, odly_inc, odly_cntvaluein, odatain,
      input  idly_cntvalueout, idataout, odly_cntvalueout, odataout, rdy
   );
   modport slave (
      input  idly_ld, idly_ce, idly_inc, idly_cntvaluein, idatain,
      input  odly_ld, odly_ce, odly_inc, odly_cntvaluein, odatain,
      output idly_cntvalueout, idataout, odly_cntvalueout, odataout, rdy
   );
endinterface

// File: rtl/io_delay_chan.sv
// io_delay_chan: one delay channel -- tap register, 32-stage shift line, output mux.
module io_delay_chan
   import io_delay_pkg::*;
#(
   parameter int unsigned DELAY_VALUE = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic ld,
   input  logic ce,
   input  logic inc,
   input  tap_t cntvaluein,
   output tap_t cntvalueout,
   input  logic datain,
   output logic dataout
);
   tap_t tap_q, tap_d;
   logic [NUM_TAPS-1:0] line_q, line_d;
   // Load beats step; the 5-bit add/sub wraps 31<->0 by itself.
   always_comb begin
      tap_d = tap_q;
      if (en) tap_d = ld ? cntvaluein : ce ? (inc ? tap_q + tap_t'(1) : tap_q - tap_t'(1)) : tap_q;
      line_d = {line_q[NUM_TAPS-2:0], datain};
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tap_q  <= tap_t'(DELAY_VALUE);
         line_q <= '0;
      end else begin
         tap_q  <= tap_d;
         line_q <= line_d;
      end
   end
   assign cntvalueout = tap_q;
   assign dataout = line_q[tap_q];
endmodule

// File: rtl/io_delay_line.sv
// io_delay_line: two independent programmable delay channels gated by a shared ready timer.
module io_delay_line
   import io_delay_pkg::*;
#(
   parameter int unsigned DELAY_VALUE = 0,
   parameter int unsigned RDY_CYCLES  = 16
) (
   input logic clk,
   input logic rst_n,
   io_delay_line_if.slave bus
);
   logic [7:0] cnt_q, cnt_d;
   logic rdy_q, rdy_d;
   always_comb begin
      cnt_d = rdy_q ? cnt_q : cnt_q + 8'd1;
      rdy_d = rdy_q | (cnt_d == 8'(RDY_CYCLES));
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         rdy_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rdy_q <= rdy_d;
      end
   end
   assign bus.rdy = rdy_q;
   io_delay_chan #(.DELAY_VALUE(DELAY_VALUE)) u_idly (
      .clk(clk), .rst_n(rst_n), .en(rdy_q),
      .ld(bus.idly_ld), .ce(bus.idly_ce), .inc(bus.idly_inc),
      .cntvaluein(bus.idly_cntvaluein), .cntvalueout(bus.idly_cntvalueout),
      .datain(bus.idatain), .dataout(bus.idataout)
   );
   io_delay_chan #(.DELAY_VALUE(DELAY_VALUE)) u_odly (
      .clk(clk), .rst_n(rst_n), .en(rdy_q),
      .ld(bus.odly_ld), .ce(bus.odly_ce), .inc(bus.odly_inc),
      .cntvaluein(bus.odly_cntvaluein), .cntvalueout(bus.odly_cntvalueout),
      .datain(bus.odatain), .dataout(bus.odataout)
   );
endmodule

// File: tb/tb_io_delay_line.sv
// tb_io_delay_line: directed and randomized checks of io_delay_line against a queue-based model.
module tb_io_delay_line;
   logic clk = 1'b0;
   logic rst_n;
   int errors = 0;
   int checks = 0;
   io_delay_line_if bus();
   io_delay_line #(.DELAY_VALUE(0), .RDY_CYCLES(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;

   // Reference: queue index k holds the sample captured k edges ago.
   bit q_i[$];
   bit q_o[$];
   int mt_i, mt_o, mcnt;
   bit mrdy;

   function automatic int next_tap(int t, bit ld, bit ce, bit inc, int v);
      if (ld) return v;
      if (ce) return (t + (inc ? 1 : -1) + 32) % 32;
      return t;
   endfunction

   task automatic model_update();
      if (!rst_n) begin
         q_i.delete();
         q_o.delete();
         for (int k = 0; k < 32; k++) begin
            q_i.push_back(1'b0);
            q_o.push_back(1'b0);
         end
         mt_i = 0; mt_o = 0; mcnt = 0; mrdy = 0;
      end else begin
         q_i.push_front(bus.idatain); void'(q_i.pop_back());
         q_o.push_front(bus.odatain); void'(q_o.pop_back());
         if (mrdy) begin
            mt_i = next_tap(mt_i, bus.idly_ld, bus.idly_ce, bus.idly_inc, int'(bus.idly_cntvaluein));
            mt_o = next_tap(mt_o, bus.odly_ld, bus.odly_ce, bus.odly_inc, int'(bus.odly_cntvaluein));
         end else begin
            mcnt++;
            if (mcnt == 16) mrdy = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.idly_ld = 0; bus.idly_ce = 0; bus.idly_inc = 0; bus.idly_cntvaluein = '0; bus.idatain = 0;
      bus.odly_ld = 0; bus.odly_ce = 0; bus.odly_inc = 0; bus.odly_cntvaluein = '0; bus.odatain = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle();
      repeat (10) tick();
      checks++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", bus.rdy); end
      checks++; if (bus.idataout !== 1'b0 || bus.odataout !== 1'b0) begin errors++; $display("FAIL reset_dataout got=%b%b exp=00", bus.idataout, bus.odataout); end
      checks++; if (bus.idly_cntvalueout !== 5'd0 || bus.odly_cntvalueout !== 5'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.idly_cntvalueout, bus.odly_cntvalueout); end
      rst_n = 1;
      for (int i = 1; i <= 16; i++) begin
         if (i == 3) begin bus.idly_ld = 1; bus.idly_cntvaluein = 5'd9; bus.odly_ce = 1; bus.odly_inc = 1; end
         if (i == 4) idle();
         tick();
         checks++; if (bus.rdy !== (i == 16)) begin errors++; $display("FAIL rdy_timing cyc=%0d got=%b exp=%b", i, bus.rdy, i == 16); end
      end
      checks++; if (bus.idly_cntvalueout !== 5'd0 || bus.odly_cntvalueout !== 5'd0) begin errors++; $display("FAIL ctrl_ignored_not_rdy got=%0d/%0d exp=0/0", bus.idly_cntvalueout, bus.odly_cntvalueout); end
   endtask

   task automatic test_tap0();
      bus.idly_ld = 1; bus.idly_cntvaluein = 5'd0;
      tick();
      idle();
      checks++; if (bus.idly_cntvalueout !== 5'd0) begin errors++; $display("FAIL tap0_cnt got=%0d exp=0", bus.idly_cntvalueout); end
      bus.idatain = 1;
      tick();
      bus.idatain = 0;
      checks++; if (bus.idataout !== 1'b1) begin errors++; $display("FAIL tap0_pulse got=%b exp=1", bus.idataout); end
      tick();
      checks++; if (bus.idataout !== 1'b0) begin errors++; $display("FAIL tap0_pulse_end got=%b exp=0", bus.idataout); end
   endtask

   task automatic test_tap31();
      bus.odly_ld = 1; bus.odly_cntvaluein = 5'd31;
      tick();
      idle();
      checks++; if (bus.odly_cntvalueout !== 5'd31) begin errors++; $display("FAIL tap31_cnt got=%0d exp=31", bus.odly_cntvalueout); end
      bus.odatain = 1;
      tick();
      bus.odatain = 0;
      for (int k = 0; k <= 32; k++) begin
         checks++; if (bus.odataout !== (k == 31)) begin errors++; $display("FAIL tap31_pulse k=%0d got=%b exp=%b", k, bus.odataout, k == 31); end
         tick();
      end
      checks++; if (bus.idly_cntvalueout !== 5'd0) begin errors++; $display("FAIL chan_indep got=%0d exp=0", bus.idly_cntvalueout); end
   endtask

   task automatic test_wrap();
      bus.idly_ld = 1; bus.idly_cntvaluein = 5'd31;
      tick();
      bus.idly_ld = 0; bus.idly_ce = 1; bus.idly_inc = 1;
      tick();
      checks++; if (bus.idly_cntvalueout !== 5'd0) begin errors++; $display("FAIL wrap_up got=%0d exp=0", bus.idly_cntvalueout); end
      bus.idly_inc = 0;
      tick();
      checks++; if (bus.idly_cntvalueout !== 5'd31) begin errors++; $display("FAIL wrap_down got=%0d exp=31", bus.idly_cntvalueout); end
      idle();
      bus.odly_ld = 1; bus.odly_cntvaluein = 5'd0;
      tick();
      bus.odly_ld = 0; bus.odly_ce = 1; bus.odly_inc = 0;
      tick();
      idle();
      checks++; if (bus.odly_cntvalueout !== 5'd31) begin errors++; $display("FAIL owrap_down got=%0d exp=31", bus.odly_cntvalueout); end
   endtask

   task automatic test_priority();
      bus.idly_ld = 1; bus.idly_cntvaluein = 5'd7; bus.idly_ce = 1; bus.idly_inc = 1;
      tick();
      idle();
      checks++; if (bus.idly_cntvalueout !== 5'd7) begin errors++; $display("FAIL ld_priority got=%0d exp=7", bus.idly_cntvalueout); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         bus.idly_ld = ($urandom_range(0, 15) == 0); bus.idly_ce = $urandom_range(0, 1); bus.idly_inc = $urandom_range(0, 1);
         bus.idly_cntvaluein = 5'($urandom); bus.idatain = $urandom_range(0, 1);
         bus.odly_ld = ($urandom_range(0, 15) == 0); bus.odly_ce = $urandom_range(0, 1); bus.odly_inc = $urandom_range(0, 1);
         bus.odly_cntvaluein = 5'($urandom); bus.odatain = $urandom_range(0, 1);
         tick();
         checks++; if (bus.idly_cntvalueout !== 5'(mt_i)) begin errors++; $display("FAIL rand_itap cyc=%0d got=%0d exp=%0d", c, bus.idly_cntvalueout, mt_i); end
         checks++; if (bus.odly_cntvalueout !== 5'(mt_o)) begin errors++; $display("FAIL rand_otap cyc=%0d got=%0d exp=%0d", c, bus.odly_cntvalueout, mt_o); end
         checks++; if (bus.idataout !== q_i[mt_i]) begin errors++; $display("FAIL rand_idata cyc=%0d got=%b exp=%b", c, bus.idataout, q_i[mt_i]); end
         checks++; if (bus.odataout !== q_o[mt_o]) begin errors++; $display("FAIL rand_odata cyc=%0d got=%b exp=%b", c, bus.odataout, q_o[mt_o]); end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      int n;
      bus.idly_ld = 1; bus.idly_cntvaluein = 5'd12;
      tick();
      idle();
      for (int c = 0; c < 20; c++) begin
         bus.idatain = 1'($urandom) | (c == 7);
         tick();
      end
      rst_n = 0; bus.idly_ld = 1; bus.idly_cntvaluein = 5'd3; bus.idatain = 1;
      tick();
      idle();
      checks++; if (bus.idly_cntvalueout !== 5'd0) begin errors++; $display("FAIL midrst_tap got=%0d exp=0", bus.idly_cntvalueout); end
      checks++; if (bus.idataout !== 1'b0) begin errors++; $display("FAIL midrst_data got=%b exp=0", bus.idataout); end
      checks++; if (bus.rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy got=%b exp=0", bus.rdy); end
      rst_n = 1;
      n = 0;
      for (int c = 1; c <= 40 && n == 0; c++) begin
         tick();
         if (bus.rdy === 1'b1) n = c;
      end
      checks++; if (n != 16) begin errors++; $display("FAIL midrst_rdy_delay got=%0d exp=16", n); end
   endtask

   initial begin
      rst_n = 0;
      idle();
      test_reset();
      test_tap0();
      test_tap31();
      test_wrap();
      test_priority();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
